// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops 32-bit words from a RAM FIFO read port and sends them
// LSB byte first on a UART TX line (8N1). Defining FIFO_UART_TX_PARITY_EN
// inserts an even-parity bit after the data bits (8E1).
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_ack_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_rd_en_o,
  output logic             uart_tx_o,
  output logic             busy_o,
  output logic             word_done_o
);

  localparam int unsigned NBytes = WIDTH / 8;
  localparam int unsigned BaudW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ByteW  = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [ByteW-1:0] LastByte = ByteW'(NBytes - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle, StReq, StWait, StStart, StData, StParity, StStop
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StReq, StWait, StStart, StData, StStop
  } state_e;
`endif

  state_e             state_q;
  logic [WIDTH-1:0]   word_q;      // shifts right one bit per data bit sent
  logic [ByteW-1:0]   byte_idx_q;
  logic [2:0]         bit_idx_q;
  logic [BaudW-1:0]   baud_q;
  logic               tx_q;
  logic               done_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic               par_q;
`endif

  logic baud_end;
  assign baud_end = (baud_q == BaudMax);

  // Drain FSM with registered line and done pulse; tx_q is loaded with the
  // level of the state being entered so the line changes on the transition edge.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q    <= StIdle;
      word_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (enable_i && !fifo_empty_i) state_q <= StReq;
        end
        StReq: begin
          state_q <= StWait;
        end
        StWait: begin
          if (fifo_ack_i) begin
            word_q     <= fifo_data_i;
            byte_idx_q <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b0;
            state_q    <= StStart;
          end else begin
            state_q <= StIdle;
          end
        end
        StStart: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= word_q[0];
            state_q   <= StData;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q     <= ^word_q[7:0];
`endif
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_end) begin
            baud_q <= '0;
            word_q <= word_q >> 1;
            if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= word_q[1];
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        StParity: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
`endif
        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_idx_q == LastByte) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              byte_idx_q <= byte_idx_q + ByteW'(1);
              tx_q       <= 1'b0;
              state_q    <= StStart;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign fifo_rd_en_o = (state_q == StReq);
  assign busy_o       = (state_q != StIdle);
  assign uart_tx_o    = tx_q;
  assign word_done_o  = done_q;

endmodule
